// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   DATA_WIDTH   : default payload bits per frame
//   uart_state_e : frame-level FSM state encoding
package uart_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   CLK      : clock, rising edge
//   RESET    : synchronous active-high reset, clears the counter
//   EN       : count enable; while low the counter is held at zero
//   BIT_TICK : high in the last cycle of each CLKS_PER_BIT-cycle bit period
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    output logic BIT_TICK
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET || !EN) begin
            cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign BIT_TICK = EN && (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
//   CLK      : clock, rising edge
//   RESET    : synchronous active-high reset, aborts any frame in progress
//   TX_START : send request, accepted only while idle
//   TX_DATA  : payload, latched on acceptance
//   TX_OUT   : registered serial line, idle high
//   TX_BUSY  : high while a frame is in progress
//   TX_DONE  : one-cycle pulse in the last cycle of the stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = uart_pkg::DATA_WIDTH,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  TX_START,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_OUT,
    output logic                  TX_BUSY,
    output logic                  TX_DONE
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);
    localparam logic OddBit = (PARITY_ODD != 0);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IdxW-1:0]       bit_idx_q;
    logic                  parity_q;
    logic                  tx_out_q;
    logic                  busy_q;
    logic                  baud_en;
    logic                  bit_tick;

    // Timer runs only inside a frame, so every frame starts from a fresh bit period.
    assign baud_en = (state_q != StIdle);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (baud_en),
        .BIT_TICK (bit_tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (TX_START) begin
                        state_q   <= StStart;
                        shift_q   <= TX_DATA;
                        // Parity is fixed at acceptance since the shift register is consumed.
                        parity_q  <= (^TX_DATA) ^ OddBit;
                        bit_idx_q <= '0;
                        tx_out_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_tick) begin
                        state_q  <= StData;
                        tx_out_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        if (bit_idx_q == LastIdx) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q  <= StParity;
                                tx_out_q <= parity_q;
                            end else begin
                                state_q  <= StStop;
                                tx_out_q <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_out_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                StParity: begin
                    if (bit_tick) begin
                        state_q  <= StStop;
                        tx_out_q <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    tx_out_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT  = tx_out_q;
    assign TX_BUSY = busy_q;
    // Decoded from registered state and counter only; marks the final stop-bit cycle.
    assign TX_DONE = (state_q == StStop) && bit_tick;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int Cpb = 16;

    typedef struct {
        int         s;
        logic [7:0] d;
        logic       bit9;
        int         nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [2:0] out;
    logic [2:0] busy;
    logic [2:0] done;
    int         sel;
    logic       so, sb, sd;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: even parity, 1: odd parity, 2: no parity.
    int pe_tab[3]  = '{1, 1, 0};
    int odd_tab[3] = '{0, 1, 0};

    logic exp_bits[$];
    logic cap[$];
    vec_t tab[6];

    always #5 clk = ~clk;

    uart_tx dut0 (
        .CLK(clk), .RESET(rst), .TX_START(start), .TX_DATA(data),
        .TX_OUT(out[0]), .TX_BUSY(busy[0]), .TX_DONE(done[0])
    );
    uart_tx #(.PARITY_ODD(1)) dut1 (
        .CLK(clk), .RESET(rst), .TX_START(start), .TX_DATA(data),
        .TX_OUT(out[1]), .TX_BUSY(busy[1]), .TX_DONE(done[1])
    );
    uart_tx #(.PARITY_EN(0)) dut2 (
        .CLK(clk), .RESET(rst), .TX_START(start), .TX_DATA(data),
        .TX_OUT(out[2]), .TX_BUSY(busy[2]), .TX_DONE(done[2])
    );

    always_comb begin
        so = out[sel];
        sb = busy[sel];
        sd = done[sel];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    function automatic void build_frame(input logic [7:0] d, input int s);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pe_tab[s] != 0) exp_bits.push_back((^d) ^ (odd_tab[s] != 0));
        exp_bits.push_back(1'b1);
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy !== 3'b000; i++) @(negedge clk);
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    // Called with TX_START already driven; first sample is the cycle after acceptance.
    task automatic check_frame(input logic [7:0] d, input bit drop_start, input string tag);
        int   len;
        int   busy_cnt = 0;
        int   done_cnt = 0;
        int   done_pos = -1;
        logic badv;
        build_frame(d, sel);
        len = exp_bits.size() * Cpb;
        cap.delete();
        for (int b = 0; b < exp_bits.size(); b++) begin
            badv = exp_bits[b];
            for (int c = 0; c < Cpb; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0 && drop_start) start = 1'b0;
                if (so !== exp_bits[b]) badv = so;
                if (sb === 1'b1) busy_cnt++;
                if (sd === 1'b1) begin
                    done_cnt++;
                    done_pos = b * Cpb + c;
                end
                if (c == Cpb / 2) cap.push_back(so);
            end
            check($sformatf("%s d=%0h bit%0d", tag, d, b), 32'(badv), 32'(exp_bits[b]));
        end
        check($sformatf("%s busy_cycles", tag), busy_cnt, len);
        check($sformatf("%s done_count", tag), done_cnt, 1);
        check($sformatf("%s done_pos", tag), done_pos, len - 1);
        @(negedge clk);
        check($sformatf("%s idle_gap", tag), {29'd0, so, sb, sd}, 32'b100);
    endtask

    initial begin
        logic [10:0] pk;
        int          dcnt;
        int          low_seen;

        tab[0] = '{0, 8'hA5, 1'b0, 11};
        tab[1] = '{1, 8'h01, 1'b0, 11};
        tab[2] = '{1, 8'h00, 1'b1, 11};
        tab[3] = '{2, 8'hFF, 1'b1, 10};
        tab[4] = '{0, 8'h3C, 1'b0, 11};
        tab[5] = '{1, 8'h80, 1'b0, 11};

        rst = 1'b1; start = 1'b0; data = 8'h00; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("reset_state dut%0d", s), {29'd0, so, sb, sd}, 32'b100);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            sel = tab[i].s; data = tab[i].d; start = 1'b1;
            check_frame(tab[i].d, 1'b1, "vec");
            check($sformatf("vec%0d nbits", i), cap.size(), tab[i].nbits);
            check($sformatf("vec%0d bit9", i), 32'(cap[9]), 32'(tab[i].bit9));
            if (i == 0) begin
                pk = '0;
                for (int k = 0; k < 11; k++) pk[10-k] = cap[k];
                check("a5_sequence", 32'(pk), 32'b01010010101);
            end
        end

        // TX_START with new data held during a frame must be ignored.
        wait_idle();
        sel = 0; data = 8'hA5; start = 1'b1;
        fork
            check_frame(8'hA5, 1'b1, "busy_ignore");
            begin
                repeat (20) @(negedge clk);
                start = 1'b1; data = 8'h3C;
                repeat (120) @(negedge clk);
                start = 1'b0;
            end
        join
        dcnt = 0; low_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (sd === 1'b1) dcnt++;
            if (so !== 1'b1 || sb !== 1'b0) low_seen++;
        end
        check("busy_ignore extra_done", dcnt, 0);
        check("busy_ignore line_idle", low_seen, 0);

        // Reset in the middle of data bit 3.
        wait_idle();
        sel = 0; data = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * Cpb + 5) @(negedge clk);
        check("midrst pre bit3", {30'd0, so, sb}, 32'b01);
        rst = 1'b1;
        @(negedge clk);
        check("midrst after", {29'd0, so, sb, sd}, 32'b100);
        rst = 1'b0;
        @(negedge clk);
        data = 8'h55; start = 1'b1;
        check_frame(8'h55, 1'b1, "post_reset");

        // Reset wins over a simultaneous start request.
        wait_idle();
        rst = 1'b1; start = 1'b1; data = 8'hF0;
        repeat (2) @(negedge clk);
        check("rst_priority during", {29'd0, so, sb, sd}, 32'b100);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_priority after", {29'd0, out, busy}, 32'b111000);

        // Back-to-back: start held high, data changed during first frame.
        wait_idle();
        sel = 0; data = 8'hA5; start = 1'b1;
        fork
            check_frame(8'hA5, 1'b0, "b2b_first");
            begin
                repeat (10) @(negedge clk);
                data = 8'h96;
            end
        join
        check_frame(8'h96, 1'b1, "b2b_second");

        // Randomized frames on randomly chosen parity configurations.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] rd;
            wait_idle();
            rd = 8'($urandom);
            sel = int'($urandom_range(0, 2));
            data = rd; start = 1'b1;
            check_frame(rd, 1'b1, $sformatf("rnd%0d_dut%0d", i, sel));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8 (`DATA_WIDTH), payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, CLK cycles per serial bit; legal range >= 2.
REQ-003 SHALL have parameter PARITY_EN, default 1; 1 inserts a parity bit.
REQ-004 SHALL have parameter PARITY_ODD, default 0; 0 means even parity, 1 means odd parity.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port TX_START, input, 1 bit: request to send TX_DATA.
REQ-008 SHALL have port TX_DATA, input, DATA_WIDTH bits: payload, sampled only on accept.
REQ-009 SHALL have port TX_OUT, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port TX_BUSY, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port TX_DONE, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-013 SHALL accept a request when TX_START=1 in IDLE; TX_DATA is latched into a shift register that cycle; acceptance is the only handshake.
REQ-014 SHALL ignore TX_START in any non-IDLE state; the latched data is unaffected.
REQ-015 SHALL drive TX_OUT low from the cycle after acceptance for CLKS_PER_BIT cycles (START).
REQ-016 SHALL send DATA_WIDTH data bits LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL send the parity bit as the XOR of the latched data, inverted when PARITY_ODD=1, for CLKS_PER_BIT cycles.
REQ-018 SHALL drive TX_OUT high for one stop bit of CLKS_PER_BIT cycles.
REQ-019 SHALL keep a baud counter counting 0..CLKS_PER_BIT-1 that wraps to 0 at each bit boundary, and a bit index counting 0..DATA_WIDTH-1 in DATA.
REQ-020 SHALL pulse TX_DONE in the last cycle of STOP, then enter IDLE.
REQ-021 SHALL deassert TX_BUSY in IDLE and assert it in all other states. In IDLE, TX_OUT SHALL be 1.
REQ-022 SHALL accept a TX_START present in the first IDLE cycle after TX_DONE, giving a one-cycle idle-high gap between back-to-back frames.
REQ-023 SHALL keep the total frame length at (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.
REQ-024 SHALL register TX_OUT, with no combinational path from inputs to TX_OUT.

Reset
REQ-025 SHALL, while RESET=1 (including mid-frame), force IDLE, TX_OUT=1, TX_BUSY=0, TX_DONE=0, and clear the counters and shift register.
REQ-026 SHALL give RESET priority over TX_START in the same cycle; no frame is started.

Structure
REQ-027 SHALL take DATA_WIDTH and the FSM state encoding from shared package uart_pkg, which is also used by the receiver.
REQ-028 SHALL place the baud counter in sub-module uart_baud_gen (ports CLK, RESET, EN, BIT_TICK), shared with the receiver.

Verification
REQ-029 SHALL verify a single frame: TX_DATA=0xA5, even parity, CLKS_PER_BIT=16.
- Expected line sequence: 0, 1,0,1,0,0,1,0,1, parity 0, 1.
- Each bit lasts 16 cycles; total frame 176 cycles.
- One TX_DONE pulse occurs.
REQ-030 SHALL verify odd parity: PARITY_ODD=1, TX_DATA=0x01 -> parity bit 0; TX_DATA=0x00 -> parity bit 1.
REQ-031 SHALL verify busy-ignore: TX_START with 0x3C held during a frame of 0xA5 -> only the 0xA5 frame is sent, and there is exactly one TX_DONE.
REQ-032 SHALL verify mid-frame reset: RESET during DATA bit 3 -> TX_OUT=1 and TX_BUSY=0 the next cycle; a new 0x55 request then produces a clean frame.
REQ-033 SHALL verify back-to-back frames: TX_START held high continuously -> frames separated by exactly one idle-high cycle.
REQ-034 SHALL verify parity disabled: PARITY_EN=0, TX_DATA=0xFF -> frame of 10 bits (160 cycles), with no parity bit.
